// File: rtl/lc3_mem_sequencer.sv
// lc3_mem_sequencer: owns the single LC3 memory port and shares it between
// instruction fetch and execute-stage load/store, including the two-access
// pointer-then-data sequence used by LDI/STI.
//
// Handshake (both requesters): req is a level held until the matching ack.
// ack is a one-cycle pulse in RESP. For fetches and loads the returned data
// is valid in that same cycle. The requester drops req on the edge that ends
// the ack cycle. A req still high in the following IDLE cycle is a new request.
module lc3_mem_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic        d_ind,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_ack,
  output logic [15:0] d_rdata,
  output logic [15:0] addr,
  output logic [15:0] din,
  output logic        rd,
  input  logic [15:0] dout,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    F_RD  = 3'd1,
    D_PTR = 3'd2,
    D_RD  = 3'd3,
    D_WR  = 3'd4,
    RESP  = 3'd5
  } state_t;

  // Counter reload value: a phase lasts MEM_LAT cycles, ending when cnt==0.
  localparam logic [2:0] LAT_LOAD = 3'(MEM_LAT - 1);

  state_t      state, state_n;
  logic [2:0]  cnt, cnt_n;

  // last_grant/cur_data: 1 = data requester, 0 = fetch requester.
  logic        last_grant;
  logic        cur_data;
  logic [15:0] lat_f_addr;
  logic [15:0] lat_d_addr;
  logic [15:0] lat_wdata;
  logic        lat_we;
  logic        lat_ind;
  logic [15:0] ptr;
  logic [15:0] f_data_q;
  logic [15:0] d_rdata_q;

  logic        grant_d;
  logic        grant_f;
  logic        phase_done;
  logic        bus_en;
  logic [15:0] addr_val;

  // Round-robin on conflict: data wins unless data was the last grant.
  assign grant_d    = d_req && (!f_req || !last_grant);
  assign grant_f    = f_req && !grant_d;
  assign phase_done = (cnt == 3'd0);

  // State and wait-counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (grant_d) begin
          cnt_n = LAT_LOAD;
          if (d_ind)     state_n = D_PTR;
          else if (d_we) state_n = D_WR;
          else           state_n = D_RD;
        end else if (grant_f) begin
          cnt_n   = LAT_LOAD;
          state_n = F_RD;
        end
      end
      F_RD, D_RD, D_WR: begin
        if (!phase_done) cnt_n = cnt - 3'd1;
        else             state_n = RESP;
      end
      D_PTR: begin
        if (!phase_done) begin
          cnt_n = cnt - 3'd1;
        end else begin
          cnt_n   = LAT_LOAD;
          state_n = lat_we ? D_WR : D_RD;
        end
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Grant bookkeeping, request latching and read-data capture.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b0;
      cur_data   <= 1'b0;
      lat_f_addr <= 16'h0000;
      lat_d_addr <= 16'h0000;
      lat_wdata  <= 16'h0000;
      lat_we     <= 1'b0;
      lat_ind    <= 1'b0;
      ptr        <= 16'h0000;
      f_data_q   <= 16'h0000;
      d_rdata_q  <= 16'h0000;
    end else begin
      if (state == IDLE) begin
        if (grant_d) begin
          last_grant <= 1'b1;
          cur_data   <= 1'b1;
          lat_d_addr <= d_addr;
          lat_wdata  <= d_wdata;
          lat_we     <= d_we;
          lat_ind    <= d_ind;
        end else if (grant_f) begin
          last_grant <= 1'b0;
          cur_data   <= 1'b0;
          lat_f_addr <= f_addr;
        end
      end
      if (phase_done) begin
        if (state == F_RD)  f_data_q  <= dout;
        if (state == D_PTR) ptr       <= dout;
        if (state == D_RD)  d_rdata_q <= dout;
      end
    end
  end

  // Bus address selection from the registered state only.
  always_comb begin
    bus_en   = 1'b0;
    addr_val = 16'h0000;
    case (state)
      F_RD:  begin bus_en = 1'b1; addr_val = lat_f_addr; end
      D_PTR: begin bus_en = 1'b1; addr_val = lat_d_addr; end
      D_RD:  begin bus_en = 1'b1; addr_val = lat_ind ? ptr : lat_d_addr; end
      D_WR:  begin bus_en = 1'b1; addr_val = lat_ind ? ptr : lat_d_addr; end
      default: begin bus_en = 1'b0; addr_val = 16'h0000; end
    endcase
  end

  assign addr      = bus_en ? addr_val : 16'hzzzz;
  assign rd        = bus_en ? (state != D_WR) : 1'bz;
  assign din       = (state == D_WR) ? lat_wdata : 16'hzzzz;
  assign f_ack     = (state == RESP) && !cur_data;
  assign d_ack     = (state == RESP) && cur_data;
  assign f_data    = f_data_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Bench for lc3_mem_sequencer: main instance at MEM_LAT=2, a second instance
// at MEM_LAT=1 for the single-cycle fetch case; both share one memory model.
module tb_lc3_mem_sequencer;

  localparam int LAT = 2;
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_D_PTR = 3'd2;
  localparam logic [2:0] ST_D_WR  = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- main DUT (MEM_LAT=2) ----------------
  logic        f_req, d_req, d_we, d_ind;
  logic [15:0] f_addr, d_addr, d_wdata;
  wire         f_ack, d_ack, rd, busy;
  wire  [15:0] f_data, d_rdata, addr, din, dout;
  wire  [2:0]  dbg_state;

  lc3_mem_sequencer #(.MEM_LAT(LAT)) dut (
    .clock(clk), .reset(rst_n),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_data(f_data),
    .d_req(d_req), .d_we(d_we), .d_ind(d_ind), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .addr(addr), .din(din), .rd(rd), .dout(dout), .busy(busy),
    .dbg_state(dbg_state)
  );

  // ---------------- second DUT (MEM_LAT=1) ----------------
  logic        f1_req;
  logic [15:0] f1_addr;
  logic        tie0;
  logic [15:0] tie16;
  wire         f1_ack, d1_ack, rd1, busy1;
  wire  [15:0] f1_data, d1_rdata, addr1, din1, dout1;
  wire  [2:0]  dbg1;

  lc3_mem_sequencer #(.MEM_LAT(1)) dut1 (
    .clock(clk), .reset(rst_n),
    .f_req(f1_req), .f_addr(f1_addr), .f_ack(f1_ack), .f_data(f1_data),
    .d_req(tie0), .d_we(tie0), .d_ind(tie0), .d_addr(tie16),
    .d_wdata(tie16), .d_ack(d1_ack), .d_rdata(d1_rdata),
    .addr(addr1), .din(din1), .rd(rd1), .dout(dout1), .busy(busy1),
    .dbg_state(dbg1)
  );

  // ---------------- memory model ----------------
  logic [15:0] mem [0:65535];
  assign dout  = mem[addr];
  assign dout1 = mem[addr1];

  always @(posedge clk) begin
    if (dbg_state == ST_D_WR && rd === 1'b0) mem[addr] = din;
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [15:0] f_exp_q[$];
  logic [15:0] d_exp_q[$];
  bit          ack_log[$];
  bit          idle_due = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the expected queue whenever an ack is presented.
  always @(negedge clk) begin
    if (rst_n) begin
      if (idle_due) check("idle_after_ack", busy, 0);
      idle_due = f_ack || d_ack;
      if (f_ack || d_ack) check("single_ack", f_ack && d_ack, 0);
      if (d_ack) begin
        ack_log.push_back(1'b1);
        if (d_exp_q.size() == 0) check("d_ack_unexpected", d_ack, 0);
        else check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
      if (f_ack) begin
        ack_log.push_back(1'b0);
        if (f_exp_q.size() == 0) check("f_ack_unexpected", f_ack, 0);
        else check("f_data", f_data, f_exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ack(input bit is_data);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 60) begin
      @(negedge clk);
      n++;
      got = is_data ? d_ack : f_ack;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_ack_timeout actual=0 required=1", is_data ? "d" : "f");
    end
    @(posedge clk);
    #1;
    if (is_data) d_req = 1'b0;
    else f_req = 1'b0;
  endtask

  task automatic fetch_txn(input logic [15:0] a, input logic [15:0] exp);
    f_exp_q.push_back(exp);
    f_addr = a;
    f_req  = 1'b1;
    wait_ack(1'b0);
  endtask

  task automatic data_txn(input bit we, input bit ind, input logic [15:0] a,
                          input logic [15:0] wd, input logic [15:0] exp);
    d_exp_q.push_back(exp);
    d_we = we; d_ind = ind; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    wait_ack(1'b1);
  endtask

  // Uncontended data access with a cycle-by-cycle bus check; start at posedge+1.
  task automatic data_trace(input bit we, input bit ind, input logic [15:0] a,
                            input logic [15:0] wd, input logic [15:0] ptr,
                            input logic [15:0] exp);
    int n_cyc;
    logic [15:0] ea;
    d_exp_q.push_back(exp);
    d_we = we; d_ind = ind; d_addr = a; d_wdata = wd;
    d_req = 1'b1;
    n_cyc = ind ? 2 * LAT : LAT;
    @(posedge clk);
    for (int c = 1; c <= n_cyc; c++) begin
      @(negedge clk);
      if (ind && c <= LAT) begin
        check("trace_ptr_addr", addr, a);
        check("trace_ptr_rd", rd, 1);
      end else begin
        ea = ind ? ptr : a;
        check("trace_addr", addr, ea);
        check("trace_rd", rd, !we);
        if (we) check("trace_din", din, wd);
      end
      check("trace_no_early_ack", d_ack, 0);
    end
    @(negedge clk);
    check("trace_ack_cycle", d_ack, 1);
    @(posedge clk);
    #1 d_req = 1'b0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    f_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_ind = 1'b0;
    f_addr = 16'h0000; d_addr = 16'h0000; d_wdata = 16'h0000;
    f1_req = 1'b0; f1_addr = 16'h0000; tie0 = 1'b0; tie16 = 16'h0000;
    mem[16'h3000] = 16'h1234;
    mem[16'h4000] = 16'h5000;
    mem[16'h5000] = 16'hBEEF;
    mem[16'h6000] = 16'h1357;
    mem[16'h7000] = 16'h2468;
    mem[16'h0100] = 16'h1111;
    mem[16'h0101] = 16'h2222;
    mem[16'h0200] = 16'h3333;
    mem[16'h0201] = 16'h4444;
    mem[16'hFFFF] = 16'h7777;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_f_ack", f_ack, 0);
    check("rst_d_ack", d_ack, 0);
    check("rst_f_data", f_data, 16'h0000);
    check("rst_d_rdata", d_rdata, 16'h0000);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_busy1", busy1, 0);
    rst_n = 1'b1;

    // Test 1: direct fetch at MEM_LAT=1
    f1_addr = 16'h3000;
    f1_req  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t1_rd", rd1, 1);
    check("t1_addr", addr1, 16'h3000);
    check("t1_no_ack", f1_ack, 0);
    @(negedge clk);
    check("t1_ack", f1_ack, 1);
    check("t1_f_data", f1_data, 16'h1234);
    check("t1_d_ack", d1_ack, 0);
    @(posedge clk);
    #1 f1_req = 1'b0;
    @(negedge clk);
    check("t1_idle_busy", busy1, 0);
    check("t1_idle_state", dbg1, ST_IDLE);

    // Test 2: LDI, pointer 4000 -> 5000 -> BEEF
    @(posedge clk);
    #1 data_trace(1'b0, 1'b1, 16'h4000, 16'h0000, 16'h5000, 16'hBEEF);

    // Test 3: STI of A5A5 through the same pointer; d_rdata stays BEEF
    data_trace(1'b1, 1'b1, 16'h4000, 16'hA5A5, 16'h5000, 16'hBEEF);
    check("t3_mem_written", mem[16'h5000], 16'hA5A5);

    // Boundary address, direct store then load
    fetch_txn(16'hFFFF, 16'h7777);
    data_trace(1'b1, 1'b0, 16'h0300, 16'h5A5A, 16'h0000, 16'hBEEF);
    check("direct_store_mem", mem[16'h0300], 16'h5A5A);
    data_trace(1'b0, 1'b0, 16'h0300, 16'h0000, 16'h0000, 16'h5A5A);

    // Test 4: simultaneous requests right after reset -> D F D F
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    ack_log.delete();
    fork
      begin
        data_txn(1'b0, 1'b0, 16'h0200, 16'h0000, 16'h3333);
        data_txn(1'b0, 1'b0, 16'h0201, 16'h0000, 16'h4444);
      end
      begin
        fetch_txn(16'h0100, 16'h1111);
        fetch_txn(16'h0101, 16'h2222);
      end
    join
    check("t4_ack_count", ack_log.size(), 4);
    if (ack_log.size() == 4) begin
      check("t4_order0", ack_log[0], 1);
      check("t4_order1", ack_log[1], 0);
      check("t4_order2", ack_log[2], 1);
      check("t4_order3", ack_log[3], 0);
    end

    // Test 5: reset during D_PTR, then restart with d_req still high
    @(posedge clk);
    #1;
    d_we = 1'b0; d_ind = 1'b1; d_addr = 16'h4000; d_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_in_ptr", dbg_state, ST_D_PTR);
    check("t5_ptr_addr", addr, 16'h4000);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_state", dbg_state, ST_IDLE);
    check("t5_rst_d_ack", d_ack, 0);
    check("t5_rst_f_data", f_data, 16'h0000);
    check("t5_rst_d_rdata", d_rdata, 16'h0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    d_exp_q.push_back(16'hA5A5);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("t5_restart_state", dbg_state, ST_D_PTR);
    check("t5_restart_addr", addr, 16'h4000);
    check("t5_restart_rd", rd, 1);
    wait_ack(1'b1);

    // Test 6: d_addr changes after the grant; latched address is used
    d_exp_q.push_back(16'h1357);
    d_we = 1'b0; d_ind = 1'b0; d_addr = 16'h6000; d_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 d_addr = 16'h7000;
    @(negedge clk);
    check("t6_latched_addr", addr, 16'h6000);
    wait_ack(1'b1);

    repeat (3) @(posedge clk);
    check("f_queue_drained", f_exp_q.size(), 0);
    check("d_queue_drained", d_exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
